// File: rtl/led_panel_pkg.sv
// Shared types and default geometry for the HUB75 scan driver.
package led_panel_pkg;

  localparam int COLS = 1 << 6;
  localparam int ROWS = 1 << 4;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LATCH,
    BLANK,
    DISPLAY,
    VSYNC
  } scan_state_t;

  typedef struct packed {
    logic r1;
    logic g1;
    logic b1;
    logic r2;
    logic g2;
    logic b2;
  } pix_t;

  typedef struct packed {
    pix_t data;
    logic clk;
    logic lat;
    logic oe_n;
  } hub75_t;

endpackage

// File: rtl/led_panel_col_shifter.sv
// Column slot sequencer: walks every column once per SHIFT pass, makes panel_clk
// and captures the responder's pixel bits PIXEL_LATENCY cycles into each slot.
module led_panel_col_shifter
  import led_panel_pkg::*;
#(
  parameter int COLS_LINES    = 6,
  parameter int CLK_DIV       = 3,
  parameter int PIXEL_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  pix_t                  pix,
  output logic [COLS_LINES-1:0] col,
  output logic                  panel_clk,
  output pix_t                  data,
  output logic                  last_col_done
);

  localparam int SW = $clog2(2 * CLK_DIV);

  logic [SW-1:0] slot;
  logic          slot_last;

  assign slot_last = (slot == SW'(2 * CLK_DIV - 1));

  // Slot and column restart from zero whenever a pass is not running.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      slot <= '0;
      col  <= '0;
    end else if (slot_last) begin
      slot <= '0;
      col  <= col + COLS_LINES'(1);
    end else begin
      slot <= slot + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      data <= '0;
    else if (run && slot == SW'(PIXEL_LATENCY))
      data <= pix;
  end

  assign panel_clk     = run && (slot >= SW'(CLK_DIV));
  assign last_col_done = run && (&col) && slot_last;

endmodule

// File: rtl/led_panel_scan_driver.sv
// HUB75 scan driver: row/bitplane sequencing, latch, BCM on-time and v_sync gap.
// Define LED_GHOST_BLANK_EN to insert an OE-high blank after each latch.
module led_panel_scan_driver
  import led_panel_pkg::*;
#(
  parameter int DISPLAY_ROWS_LINES = $clog2(ROWS),
  parameter int DISPLAY_COLS_LINES = $clog2(COLS),
  parameter int COLOR_BITS         = 8,
  parameter int CLK_DIV            = 3,
  parameter int PIXEL_LATENCY      = 1,
  parameter int BASE_OE_CYCLES     = 4,
  parameter int VSYNC_CYCLES       = 16,
  parameter int BLANK_CYCLES       = 2
) (
  input  logic                          clock_clk,
  input  logic                          reset_rst,
  input  logic                          enable,
  output logic                          v_sync,
  output logic [DISPLAY_COLS_LINES-1:0] col1,
  output logic [DISPLAY_COLS_LINES-1:0] col2,
  output logic [DISPLAY_ROWS_LINES-1:0] row1,
  output logic [DISPLAY_ROWS_LINES-1:0] row2,
  output logic [3:0]                    bitplane1,
  output logic [3:0]                    bitplane2,
  input  logic                          red1,
  input  logic                          green1,
  input  logic                          blue1,
  input  logic                          red2,
  input  logic                          green2,
  input  logic                          blue2,
  output logic                          panel_r1,
  output logic                          panel_g1,
  output logic                          panel_b1,
  output logic                          panel_r2,
  output logic                          panel_g2,
  output logic                          panel_b2,
  output logic [DISPLAY_ROWS_LINES-1:0] panel_addr,
  output logic                          panel_clk,
  output logic                          panel_lat,
  output logic                          panel_oe_n,
  output logic                          frame_done
);

  if (!(PIXEL_LATENCY + 1 < CLK_DIV)) begin : g_bad_div
    $error("PIXEL_LATENCY+1 must be less than CLK_DIV");
  end
  if (COLOR_BITS < 1 || COLOR_BITS > 16 || BLANK_CYCLES < 1) begin : g_bad_cfg
    $error("COLOR_BITS must be 1..16 and BLANK_CYCLES at least 1");
  end

  scan_state_t                   state, state_nxt;
  logic [DISPLAY_ROWS_LINES-1:0] row, addr;
  logic [DISPLAY_COLS_LINES-1:0] col;
  logic [3:0]                    plane;
  logic [31:0]                   tmr, oe_len;
  logic                          disp_done, addr_load, sh_clk, last_col_done;
  pix_t                          pix, data;
  hub75_t                        hub;

  assign pix = '{r1: red1, g1: green1, b1: blue1, r2: red2, g2: green2, b2: blue2};

  led_panel_col_shifter #(
    .COLS_LINES    (DISPLAY_COLS_LINES),
    .CLK_DIV       (CLK_DIV),
    .PIXEL_LATENCY (PIXEL_LATENCY)
  ) u_shifter (
    .clk           (clock_clk),
    .rst           (reset_rst),
    .run           (state == SHIFT),
    .pix           (pix),
    .col           (col),
    .panel_clk     (sh_clk),
    .data          (data),
    .last_col_done (last_col_done)
  );

  assign oe_len = 32'(BASE_OE_CYCLES) << plane;

  always_ff @(posedge clock_clk) begin
    if (reset_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    hub        = '0;
    hub.data   = data;
    hub.clk    = sh_clk;
    hub.oe_n   = 1'b1;
    v_sync     = 1'b0;
    frame_done = 1'b0;
    disp_done  = 1'b0;
    case (state)
      IDLE:    if (enable) state_nxt = SHIFT;
      SHIFT:   if (last_col_done) state_nxt = LATCH;
      LATCH: begin
        hub.lat = 1'b1;
`ifdef LED_GHOST_BLANK_EN
        if (tmr == 32'd1) state_nxt = BLANK;
`else
        if (tmr == 32'd1) state_nxt = DISPLAY;
`endif
      end
      BLANK:   if (tmr == 32'(BLANK_CYCLES - 1)) state_nxt = DISPLAY;
      DISPLAY: begin
        hub.oe_n = 1'b0;
        if (tmr == oe_len - 32'd1) begin
          disp_done = 1'b1;
          state_nxt = (plane == 4'(COLOR_BITS - 1) && (&row)) ? VSYNC : SHIFT;
        end
      end
      VSYNC: begin
        v_sync = 1'b1;
        if (tmr == 32'(VSYNC_CYCLES - 1)) begin
          frame_done = 1'b1;
          state_nxt  = enable ? SHIFT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One timer serves every timed state; it restarts on each state change.
  always_ff @(posedge clock_clk) begin
    if (reset_rst || state_nxt != state || state == IDLE) tmr <= '0;
    else                                                  tmr <= tmr + 32'd1;
  end

  always_ff @(posedge clock_clk) begin
    if (reset_rst || state == IDLE) begin
      row   <= '0;
      plane <= '0;
    end else if (disp_done) begin
      if (plane == 4'(COLOR_BITS - 1)) begin
        plane <= '0;
        row   <= row + DISPLAY_ROWS_LINES'(1);
      end else begin
        plane <= plane + 4'd1;
      end
    end
  end

`ifdef LED_GHOST_BLANK_EN
  assign addr_load = (state == BLANK) && (tmr == 32'd0);
`else
  assign addr_load = (state == LATCH) && (tmr == 32'd0);
`endif

  always_ff @(posedge clock_clk) begin
    if (reset_rst)      addr <= '0;
    else if (addr_load) addr <= row;
  end

  assign col1       = col;
  assign col2       = col;
  assign row1       = row;
  assign row2       = row;
  assign bitplane1  = plane;
  assign bitplane2  = plane;
  assign panel_addr = addr;
  assign panel_r1   = hub.data.r1;
  assign panel_g1   = hub.data.g1;
  assign panel_b1   = hub.data.b1;
  assign panel_r2   = hub.data.r2;
  assign panel_g2   = hub.data.g2;
  assign panel_b2   = hub.data.b2;
  assign panel_clk  = hub.clk;
  assign panel_lat  = hub.lat;
  assign panel_oe_n = hub.oe_n;

endmodule

// File: tb/tb_led_panel_scan_driver.sv
// Directed bench for led_panel_scan_driver on a 4x2 panel, 2 bitplanes.
// Build with LED_GHOST_BLANK_EN defined to exercise the blank gap.
module tb_led_panel_scan_driver;

`ifdef LED_GHOST_BLANK_EN
  localparam int FRAME = 144;
  localparam int GAP   = 3;
`else
  localparam int FRAME = 136;
  localparam int GAP   = 1;
`endif

  logic       clock_clk = 1'b0, reset_rst = 1'b1, enable = 1'b0;
  logic       v_sync, panel_clk, panel_lat, panel_oe_n, frame_done;
  logic [1:0] col1, col2;
  logic [0:0] row1, row2, panel_addr;
  logic [3:0] bitplane1, bitplane2;
  logic       red1 = 0, green1 = 0, blue1 = 0, red2 = 0, green2 = 0, blue2 = 0;
  logic       panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2;

  led_panel_scan_driver #(
    .DISPLAY_ROWS_LINES(1), .DISPLAY_COLS_LINES(2), .COLOR_BITS(2), .CLK_DIV(3),
    .PIXEL_LATENCY(1), .BASE_OE_CYCLES(4), .VSYNC_CYCLES(8), .BLANK_CYCLES(2)
  ) dut (
    .clock_clk(clock_clk), .reset_rst(reset_rst), .enable(enable), .v_sync(v_sync),
    .col1(col1), .col2(col2), .row1(row1), .row2(row2),
    .bitplane1(bitplane1), .bitplane2(bitplane2),
    .red1(red1), .green1(green1), .blue1(blue1), .red2(red2), .green2(green2), .blue2(blue2),
    .panel_r1(panel_r1), .panel_g1(panel_g1), .panel_b1(panel_b1),
    .panel_r2(panel_r2), .panel_g2(panel_g2), .panel_b2(panel_b2),
    .panel_addr(panel_addr), .panel_clk(panel_clk), .panel_lat(panel_lat),
    .panel_oe_n(panel_oe_n), .frame_done(frame_done)
  );

  always #5 clock_clk = ~clock_clk;

  int cyc = 0;
  always @(posedge clock_clk) cyc <= cyc + 1;

  // Responder with one cycle of latency
  always @(posedge clock_clk) begin
    red1   <= col1[0];
    green1 <= col1[1];
    blue1  <= row1[0];
    red2   <= bitplane1[0];
    green2 <= ~col1[0];
    blue2  <= 1'b0;
  end

  int   rise_cyc[$], fd_cyc[$], oe_run[$], oe_addr[$], gaps[$];
  logic rise_r1[$];
  logic clk_q = 1'b0, oe_q = 1'b1;
  int   lat_cyc = 0, run = 0, run_addr = 0, vs_oe = 0;

  always @(negedge clock_clk) begin
    if (panel_clk && !clk_q) begin
      rise_cyc.push_back(cyc);
      rise_r1.push_back(panel_r1);
    end
    clk_q = panel_clk;
    if (frame_done) fd_cyc.push_back(cyc);
    if (panel_lat) lat_cyc = cyc;
    if (!panel_oe_n) begin
      if (oe_q) begin
        run = 1;
        run_addr = int'(panel_addr);
        gaps.push_back(cyc - lat_cyc);
      end else run++;
      if (v_sync) vs_oe++;
    end else if (!oe_q) begin
      oe_run.push_back(run);
      oe_addr.push_back(run_addr);
    end
    oe_q = panel_oe_n;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock_clk);
    #1;
  endtask

  int t_en, rb, ob, n;
  int exp_run[4]  = '{4, 8, 4, 8};
  int exp_addr[4] = '{0, 0, 1, 1};

  initial begin
    repeat (3) tick();
    reset_rst = 1'b0;
    tick();
    chk("rst_oe_n", panel_oe_n, 1);
    chk("rst_clk", panel_clk, 0);
    chk("rst_lat", panel_lat, 0);
    chk("rst_vsync", v_sync, 0);
    chk("rst_col", col1, 0);

    // Run two full frames
    enable = 1'b1;
    t_en = cyc;
    for (int i = 0; i < 400 && fd_cyc.size() < 2; i++) tick();
    chk("fd_seen", fd_cyc.size(), 2);
    chk("first_rise", rise_cyc[0], t_en + 4);
    chk("fd0_time", fd_cyc[0], t_en + FRAME);
    chk("fd_period", fd_cyc[1] - fd_cyc[0], FRAME);
    n = 0;
    foreach (rise_cyc[i]) if (rise_cyc[i] <= fd_cyc[0]) n++;
    chk("rises_frame", n, 16);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("r1_rise%0d", i), rise_r1[i], i % 2);
      chk($sformatf("oe_run%0d", i), oe_run[i], exp_run[i]);
      chk($sformatf("oe_addr%0d", i), oe_addr[i], exp_addr[i]);
    end
    chk("lat_oe_gap", gaps[0], GAP);

    // Drop enable mid-row 0 of the third frame
    repeat (20) tick();
    enable = 1'b0;
    for (int i = 0; i < 300 && fd_cyc.size() < 3; i++) tick();
    chk("fd_after_drop", fd_cyc.size(), 3);
    chk("fd_drop_period", fd_cyc[2] - fd_cyc[1], FRAME);
    rb = rise_cyc.size();
    repeat (100) tick();
    chk("idle_no_rise", rise_cyc.size(), rb);
    chk("idle_oe_n", panel_oe_n, 1);
    chk("idle_fd_count", fd_cyc.size(), 3);

    // Reset in the middle of column 1's slot
    enable = 1'b1;
    t_en = cyc;
    repeat (11) tick();
    chk("pre_rst_col", col1, 1);
    chk("pre_rst_r1", panel_r1, 1);
    reset_rst = 1'b1;
    tick();
    chk("mid_rst_oe_n", panel_oe_n, 1);
    chk("mid_rst_clk", panel_clk, 0);
    chk("mid_rst_col", col1, 0);
    chk("mid_rst_r1", panel_r1, 0);
    chk("mid_rst_addr", panel_addr, 0);
    chk("mid_rst_plane", bitplane1, 0);
    reset_rst = 1'b0;
    t_en = cyc;
    rb = rise_cyc.size();
    ob = oe_run.size();
    for (int i = 0; i < 100 && oe_run.size() <= ob; i++) tick();
    chk("restart_rise", rise_cyc.size() > rb ? rise_cyc[rb] : 0, t_en + 4);
    chk("restart_run", oe_run.size() > ob ? oe_run[ob] : 0, 4);
    chk("restart_addr", oe_run.size() > ob ? oe_addr[ob] : 9, 0);
    chk("vsync_oe_low", vs_oe, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
